// File: rtl/tage_update_if.sv
// tage_update_if: retire update request and shared table write port.
// master drives the resolved branch; slave is the update engine.
interface tage_update_if #(
  parameter int NUM_TABLES = 12,
  parameter int IDX_W      = 11,
  parameter int TAG_W      = 15,
  parameter int CTR_W      = 3,
  parameter int U_W        = 2
);
  logic                              upd_valid;
  logic                              upd_ready;
  logic                              upd_taken;
  logic                              upd_pred;
  logic [3:0]                        upd_provider;
  logic                              upd_alt_pred;
  logic [CTR_W-1:0]                  upd_prov_ctr;
  logic [U_W-1:0]                    upd_prov_u;
  logic [(NUM_TABLES+1)*IDX_W-1:0]   upd_idx;
  logic [NUM_TABLES*TAG_W-1:0]       upd_tag;
  logic [NUM_TABLES-1:0]             upd_u_vec;
  logic                              wr_valid;
  logic                              wr_bcast;
  logic [3:0]                        wr_table;
  logic [IDX_W-1:0]                  wr_idx;
  logic [2:0]                        wr_mask;
  logic [TAG_W-1:0]                  wr_tag;
  logic [CTR_W-1:0]                  wr_ctr;
  logic [U_W-1:0]                    wr_u;
  logic [3:0]                        use_alt_on_na;

  modport master (
    output upd_valid, upd_taken, upd_pred, upd_provider,
    output upd_alt_pred, upd_prov_ctr, upd_prov_u,
    output upd_idx, upd_tag, upd_u_vec,
    input  upd_ready, wr_valid, wr_bcast, wr_table, wr_idx,
    input  wr_mask, wr_tag, wr_ctr, wr_u, use_alt_on_na
  );

  modport slave (
    input  upd_valid, upd_taken, upd_pred, upd_provider,
    input  upd_alt_pred, upd_prov_ctr, upd_prov_u,
    input  upd_idx, upd_tag, upd_u_vec,
    output upd_ready, wr_valid, wr_bcast, wr_table, wr_idx,
    output wr_mask, wr_tag, wr_ctr, wr_u, use_alt_on_na
  );
endinterface

// File: rtl/tage_update.sv
// tage_update: TAGE retire-side update engine on one shared write port.
// Option TAGE_ALLOC_RANDOM_EN: LFSR may pick the second alloc candidate.
module tage_update #(
  parameter int NUM_TABLES = 12,
  parameter int IDX_W      = 11,
  parameter int TAG_W      = 15,
  parameter int CTR_W      = 3,
  parameter int U_W        = 2,
  parameter int TICK_W     = 19
) (
  input logic        clk,
  input logic        reset,
  tage_update_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_PROV, S_ALLOC, S_DECAY, S_SWEEP
  } state_t;

  localparam logic [3:0] NT = 4'(NUM_TABLES);
  localparam logic [CTR_W-1:0] C_MAX = '1;
  localparam logic [CTR_W-1:0] C_WT = CTR_W'(1 << (CTR_W-1));
  localparam logic [CTR_W-1:0] C_WN = CTR_W'((1 << (CTR_W-1)) - 1);
  localparam logic [U_W-1:0] U_MAX = '1;

  state_t                          state;
  logic                            taken_r, mis_r, has_r;
  logic [3:0]                      sel_r;
  logic [(NUM_TABLES+1)*IDX_W-1:0] idx_r;
  logic [NUM_TABLES*TAG_W-1:0]     tag_r;
  logic [TICK_W-1:0]               tick;
  logic [3:0]                      alt_ctr;

  logic              wv_q, wb_q;
  logic [3:0]        wt_q;
  logic [IDX_W-1:0]  wi_q;
  logic [2:0]        wm_q;
  logic [TAG_W-1:0]  wg_q;
  logic [CTR_W-1:0]  wc_q;
  logic [U_W-1:0]    wu_q;

  assign bus.upd_ready     = (state == S_IDLE);
  assign bus.wr_valid      = wv_q;
  assign bus.wr_bcast      = wb_q;
  assign bus.wr_table      = wt_q;
  assign bus.wr_idx        = wi_q;
  assign bus.wr_mask       = wm_q;
  assign bus.wr_tag        = wg_q;
  assign bus.wr_ctr        = wc_q;
  assign bus.wr_u          = wu_q;
  assign bus.use_alt_on_na = alt_ctr;

`ifdef TAGE_ALLOC_RANDOM_EN
  logic [1:0] lfsr;
  logic       has2;
  logic [3:0] second;
`endif

  logic [1:0]       b_ctr;
  logic [CTR_W-1:0] p_ctr;
  logic [U_W-1:0]   p_u;
  logic [2:0]       p_mask;
  logic             p_dir, mis, has1;
  logic [3:0]       first, sel;
  logic [3:0]       alt_nx;
  logic             ending;

  // Provider write, USE_ALT_ON_NA update and alloc target from raw inputs
  always_comb begin
    b_ctr  = bus.upd_prov_ctr[1:0];
    p_ctr  = '0;
    p_u    = '0;
    p_mask = 3'b010;
    p_dir  = bus.upd_prov_ctr[CTR_W-1];
    alt_nx = alt_ctr;
    if (bus.upd_provider == 4'd0) begin
      if (bus.upd_taken) b_ctr = (b_ctr == 2'd3) ? b_ctr : b_ctr + 2'd1;
      else               b_ctr = (b_ctr == 2'd0) ? b_ctr : b_ctr - 2'd1;
      p_ctr = CTR_W'(b_ctr);
    end else begin
      p_ctr = bus.upd_prov_ctr;
      if (bus.upd_taken) p_ctr = (p_ctr == C_MAX) ? p_ctr : p_ctr + 1'b1;
      else               p_ctr = (p_ctr == '0) ? p_ctr : p_ctr - 1'b1;
      if (p_dir != bus.upd_alt_pred) begin
        p_mask = 3'b011;
        p_u    = bus.upd_prov_u;
        if (p_dir == bus.upd_taken) p_u = (p_u == U_MAX) ? p_u : p_u + 1'b1;
        else                        p_u = (p_u == '0) ? p_u : p_u - 1'b1;
        if (bus.upd_prov_u == '0 &&
            (bus.upd_prov_ctr == C_WN || bus.upd_prov_ctr == C_WT)) begin
          if (bus.upd_alt_pred == bus.upd_taken)
            alt_nx = (alt_ctr == 4'hf) ? alt_ctr : alt_ctr + 4'd1;
          else
            alt_nx = (alt_ctr == 4'h0) ? alt_ctr : alt_ctr - 4'd1;
        end
      end
    end
    mis   = (bus.upd_pred != bus.upd_taken) && (bus.upd_provider < NT);
    has1  = 1'b0;
    first = '0;
`ifdef TAGE_ALLOC_RANDOM_EN
    has2   = 1'b0;
    second = '0;
`endif
    for (int j = 1; j <= NUM_TABLES; j++) begin
      if (4'(j) > bus.upd_provider && bus.upd_u_vec[j-1]) begin
        if (!has1) begin
          has1  = 1'b1;
          first = 4'(j);
        end
`ifdef TAGE_ALLOC_RANDOM_EN
        else if (!has2) begin
          has2   = 1'b1;
          second = 4'(j);
        end
`endif
      end
    end
`ifdef TAGE_ALLOC_RANDOM_EN
    sel = (has2 && lfsr[0]) ? second : first;
`else
    sel = first;
`endif
    if (!has1) sel = bus.upd_provider + 4'd1;
    ending = (state == S_ALLOC) || (state == S_DECAY && wt_q == NT);
  end

  // Sequencer: one registered write per cycle through PROV/ALLOC/DECAY/SWEEP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      taken_r <= 1'b0;
      mis_r   <= 1'b0;
      has_r   <= 1'b0;
      sel_r   <= '0;
      idx_r   <= '0;
      tag_r   <= '0;
      tick    <= '0;
      alt_ctr <= 4'd8;
      wv_q    <= 1'b0;
      wb_q    <= 1'b0;
      wt_q    <= '0;
      wi_q    <= '0;
      wm_q    <= '0;
      wg_q    <= '0;
      wc_q    <= '0;
      wu_q    <= '0;
`ifdef TAGE_ALLOC_RANDOM_EN
      lfsr    <= 2'b01;
`endif
    end else if (ending) begin
      if (tick == '1) begin
        state <= S_SWEEP;
        wb_q  <= 1'b1;
        wt_q  <= '0;
        wi_q  <= '0;
        wm_q  <= 3'b001;
        wg_q  <= '0;
        wc_q  <= '0;
        wu_q  <= '0;
      end else begin
        state <= S_IDLE;
        wv_q  <= 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.upd_valid) begin
            state   <= S_PROV;
            taken_r <= bus.upd_taken;
            mis_r   <= mis;
            has_r   <= has1;
            sel_r   <= sel;
            idx_r   <= bus.upd_idx;
            tag_r   <= bus.upd_tag;
            alt_ctr <= alt_nx;
            wv_q    <= 1'b1;
            wb_q    <= 1'b0;
            wt_q    <= bus.upd_provider;
            wi_q    <= bus.upd_idx[bus.upd_provider*IDX_W +: IDX_W];
            wm_q    <= p_mask;
            wg_q    <= '0;
            wc_q    <= p_ctr;
            wu_q    <= p_u;
`ifdef TAGE_ALLOC_RANDOM_EN
            lfsr    <= {lfsr[0], lfsr[1] ^ lfsr[0]};
`endif
          end
        end
        S_PROV: begin
          if (!mis_r) begin
            state <= S_IDLE;
            wv_q  <= 1'b0;
          end else begin
            wt_q <= sel_r;
            wi_q <= idx_r[sel_r*IDX_W +: IDX_W];
            wu_q <= '0;
            if (has_r) begin
              state <= S_ALLOC;
              wm_q  <= 3'b111;
              wg_q  <= tag_r[(sel_r - 4'd1)*TAG_W +: TAG_W];
              wc_q  <= taken_r ? C_WT : C_WN;
              tick  <= (tick == '0) ? tick : tick - 1'b1;
            end else begin
              state <= S_DECAY;
              wm_q  <= 3'b001;
              wg_q  <= '0;
              wc_q  <= '0;
              tick  <= (tick == '1) ? tick : tick + 1'b1;
            end
          end
        end
        S_DECAY: begin
          wt_q <= wt_q + 4'd1;
          wi_q <= idx_r[(wt_q + 4'd1)*IDX_W +: IDX_W];
        end
        S_SWEEP: begin
          if (wi_q == '1) begin
            state <= S_IDLE;
            wv_q  <= 1'b0;
            wb_q  <= 1'b0;
            tick  <= '0;
          end else begin
            wi_q <= wi_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tage_update.sv
// tb_tage_update: random updates checked against a write-list model.
// TICK_W shrunk to 2 so sweeps occur; sweep length stays 2048.
module tb_tage_update;
  localparam int NT = 12;
  localparam int IW = 11;
  localparam int TW = 15;
  localparam int CW = 3;
  localparam int UW = 2;
  localparam int KW = 2;
  localparam int TMAX = (1 << KW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tage_update_if #(.NUM_TABLES(NT), .IDX_W(IW), .TAG_W(TW),
                   .CTR_W(CW), .U_W(UW)) bus ();

  tage_update #(.NUM_TABLES(NT), .IDX_W(IW), .TAG_W(TW),
                .CTR_W(CW), .U_W(UW), .TICK_W(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // fields not enabled by the mask (and table on broadcast) are don't-care
  function automatic logic [63:0] pack(logic rdy, logic bc, logic [3:0] t,
      logic [IW-1:0] i, logic [2:0] m, logic [TW-1:0] g,
      logic [CW-1:0] c, logic [UW-1:0] u);
    return {24'b0, rdy, bc, bc ? 4'b0 : t, i, m,
            m[2] ? g : {TW{1'b0}}, m[1] ? c : {CW{1'b0}},
            m[0] ? u : {UW{1'b0}}};
  endfunction

  bit s_taken, s_pred, s_alt;
  int s_prov, s_ctr, s_u;
  logic [(NT+1)*IW-1:0] s_idx;
  logic [NT*TW-1:0] s_tag;
  logic [NT-1:0] s_uvec;

  int tick_m = 0;
  int alt_m = 8;
  int nacc = 0;
  logic [63:0] expq[$];

  function automatic int sat(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model();
    int c, u, nc, nu, m, pick;
    bit ppred;
    int cands[$];
    expq.delete();
    if (s_prov == 0) begin
      nc = sat((s_ctr % 4) + (s_taken ? 1 : -1), 0, 3);
      expq.push_back(pack(0, 0, 0, s_idx[0 +: IW], 3'b010, 0, CW'(nc), 0));
    end else begin
      c = s_ctr;
      u = s_u;
      ppred = (c >= 4);
      nc = sat(c + (s_taken ? 1 : -1), 0, 7);
      m = 2;
      nu = 0;
      if (ppred != s_alt) begin
        m = 3;
        nu = sat(u + ((ppred == s_taken) ? 1 : -1), 0, 3);
        if (u == 0 && (c == 3 || c == 4))
          alt_m = sat(alt_m + ((s_alt == s_taken) ? 1 : -1), 0, 15);
      end
      expq.push_back(pack(0, 0, 4'(s_prov), s_idx[s_prov*IW +: IW],
                          3'(m), 0, CW'(nc), UW'(nu)));
    end
    if (s_pred != s_taken && s_prov < NT) begin
      for (int j = s_prov + 1; j <= NT; j++)
        if (s_uvec[j-1]) cands.push_back(j);
      if (cands.size() > 0) begin
        pick = cands[0];
`ifdef TAGE_ALLOC_RANDOM_EN
        if (cands.size() > 1 && (nacc % 3) != 2) pick = cands[1];
`endif
        expq.push_back(pack(0, 0, 4'(pick), s_idx[pick*IW +: IW], 3'b111,
                            s_tag[(pick-1)*TW +: TW],
                            CW'(s_taken ? 4 : 3), 0));
        tick_m = sat(tick_m - 1, 0, TMAX);
      end else begin
        for (int j = s_prov + 1; j <= NT; j++)
          expq.push_back(pack(0, 0, 4'(j), s_idx[j*IW +: IW],
                              3'b001, 0, 0, 0));
        tick_m = sat(tick_m + 1, 0, TMAX);
      end
      if (tick_m == TMAX) begin
        for (int i = 0; i < (1 << IW); i++)
          expq.push_back(pack(0, 1, 0, IW'(i), 3'b001, 0, 0, 0));
        tick_m = 0;
      end
    end
    nacc++;
  endfunction

  task automatic fill_addr();
    for (int k = 0; k <= NT; k++) s_idx[k*IW +: IW] = IW'($urandom);
    for (int k = 0; k < NT; k++) s_tag[k*TW +: TW] = TW'($urandom);
  endtask

  task automatic drive();
    bus.upd_taken    = s_taken;
    bus.upd_pred     = s_pred;
    bus.upd_alt_pred = s_alt;
    bus.upd_provider = 4'(s_prov);
    bus.upd_prov_ctr = CW'(s_ctr);
    bus.upd_prov_u   = UW'(s_u);
    bus.upd_idx      = s_idx;
    bus.upd_tag      = s_tag;
    bus.upd_u_vec    = s_uvec;
    bus.upd_valid    = 1'b1;
  endtask

  task automatic run(string name);
    int n;
    bit done;
    model();
    @(negedge clk);
    check({name, ".rdy_in"}, 64'(bus.upd_ready), 64'd1);
    drive();
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    n = 0;
    done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.wr_valid) begin
        done = 1;
      end else begin
        if (n < expq.size())
          check($sformatf("%s.w%0d", name, n),
                pack(bus.upd_ready, bus.wr_bcast, bus.wr_table, bus.wr_idx,
                     bus.wr_mask, bus.wr_tag, bus.wr_ctr, bus.wr_u),
                expq[n]);
        n++;
      end
    end
    check({name, ".nwr"}, 64'(n), 64'(expq.size()));
    check({name, ".rdy_out"}, 64'(bus.upd_ready), 64'd1);
    check({name, ".alt"}, 64'(bus.use_alt_on_na), 64'(alt_m));
  endtask

  initial begin
    bus.upd_valid = 0;
    bus.upd_taken = 0;
    bus.upd_pred = 0;
    bus.upd_alt_pred = 0;
    bus.upd_provider = 0;
    bus.upd_prov_ctr = 0;
    bus.upd_prov_u = 0;
    bus.upd_idx = 0;
    bus.upd_tag = 0;
    bus.upd_u_vec = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst.wr_mask", 64'(bus.wr_mask), 64'd0);
    check("rst.wr_table", 64'(bus.wr_table), 64'd0);
    check("rst.ready", 64'(bus.upd_ready), 64'd1);
    check("rst.alt", 64'(bus.use_alt_on_na), 64'd8);
    reset = 1'b1;

    fill_addr();
    s_uvec = 0; s_prov = 0; s_ctr = 2; s_u = 0;
    s_taken = 1; s_pred = 1; s_alt = 0;
    run("base_ok");

    fill_addr();
    s_prov = 3; s_ctr = 7; s_u = 3; s_taken = 1; s_pred = 1; s_alt = 0;
    run("prov_alt");

    fill_addr();
    s_prov = 4; s_ctr = 3; s_u = 0; s_taken = 1; s_pred = 0; s_alt = 1;
    s_uvec = 0;
    run("new_alloc");

    fill_addr();
    s_prov = 2; s_ctr = 5; s_u = 1; s_taken = 0; s_pred = 1; s_alt = 1;
    s_uvec = 12'h050;
    run("alloc_t5");

    fill_addr();
    s_prov = 10; s_ctr = 5; s_u = 1; s_taken = 0; s_pred = 1; s_alt = 1;
    s_uvec = 0;
    run("decay_t11");

    for (int r = 0; r < 2; r++) begin
      fill_addr();
      s_prov = 11;
      run($sformatf("decay_sw%0d", r));
    end

    fill_addr();
    s_prov = 0; s_ctr = 1; s_taken = 0; s_pred = 1; s_uvec = 0;
    model();
    @(negedge clk);
    drive();
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid.wr_valid", 64'(bus.wr_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid.wr_valid", 64'(bus.wr_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick_m = 0; alt_m = 8; nacc = 0;
    @(negedge clk);
    check("rst_mid.ready", 64'(bus.upd_ready), 64'd1);
    check("rst_mid.alt", 64'(bus.use_alt_on_na), 64'd8);

    for (int r = 0; r < 60; r++) begin
      fill_addr();
      s_prov = $urandom_range(0, NT);
      s_ctr = $urandom_range(0, 7);
      s_u = $urandom_range(0, 3);
      s_taken = 1'($urandom);
      s_alt = 1'($urandom);
      s_pred = ($urandom_range(0, 1) == 0) ? s_taken : !s_taken;
      s_uvec = ($urandom_range(0, 1) == 0) ? '0 : NT'($urandom);
      run($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tage_update.md
Name: tage_update

Overview:
- Retire-side update engine for the TAGE predictor; the write-back counterpart of the prediction lookup path.
- Accepts one resolved branch plus its prediction-time metadata and serializes every required table write onto a single write port shared by the base table T0 and tagged tables T1..T(NUM_TABLES).
- Write kinds: counter/useful updates, entry allocation on mispredict, useful-bit decay.
- Owns the USE_ALT_ON_NA counter and the TICK counter, and runs the periodic useful-bit sweep.

Parameters:
- NUM_TABLES, 12, number of tagged tables (table IDs 1..NUM_TABLES; ID 0 = base T0)
- IDX_W, 11, max table index width; smaller tables ignore upper bits
- TAG_W, 15, max tag width; narrower tables ignore upper bits
- CTR_W, 3, tagged-entry prediction counter width
- U_W, 2, useful counter width
- TICK_W, 19, TICK counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- upd_valid  in  1  resolved branch present
- upd_ready  out  1  engine idle and able to accept
- upd_taken  in  1  actual outcome
- upd_pred  in  1  final prediction issued
- upd_provider  in  4  provider table ID (0 = base)
- upd_alt_pred  in  1  alternate prediction
- upd_prov_ctr  in  CTR_W  provider counter at lookup (base uses low 2 bits)
- upd_prov_u  in  U_W  provider useful bits at lookup
- upd_idx  in  (NUM_TABLES+1)*IDX_W  per-table index, slice k = table k
- upd_tag  in  NUM_TABLES*TAG_W  per-tagged-table computed tag, slice k-1 = table k
- upd_u_vec  in  NUM_TABLES  per-tagged-table flag: indexed entry u==0
- wr_valid  out  1  write strobe
- wr_bcast  out  1  write applies to all tagged tables at wr_idx
- wr_table  out  4  target table ID
- wr_idx  out  IDX_W  target index
- wr_mask  out  3  field enables {tag,ctr,u}
- wr_tag  out  TAG_W  tag data
- wr_ctr  out  CTR_W  counter data
- wr_u  out  U_W  useful data
- use_alt_on_na  out  4  current USE_ALT_ON_NA value

Behaviour:
- Reset values:
  - All wr_* outputs 0.
  - upd_ready 1.
  - use_alt_on_na 8.
  - TICK 0.
  - 2-bit LFSR seed 2'b01.
  - FSM in IDLE.
  - Reset mid-operation abandons pending writes; nothing is replayed.
- Handshake:
  - upd_ready=1 only in IDLE.
  - Transfer on upd_valid&&upd_ready; all inputs latched that cycle.
- FSM: IDLE -> PROV -> {ALLOC | DECAY | IDLE} -> {SWEEP | IDLE}.
  - SWEEP -> IDLE.
- Write outputs are registered; each non-idle state issues at most one write per cycle.
  - First write (PROV) appears the cycle after transfer.
- PROV, provider=0:
  - Write T0 with mask {0,1,0].
  - Counter = 2-bit saturating: +1 on taken, -1 on not-taken.
- PROV, provider>0:
  - Write ctr as CTR_W saturating.
  - If provider prediction (ctr MSB) != upd_alt_pred: u+1 if provider correct, else u-1, saturating; mask {0,1,1}.
  - Otherwise mask {0,1,0}.
- Newly-allocated provider: prov_u==0 and ctr in {2^(CTR_W-1)-1, 2^(CTR_W-1)}.
  - If additionally alt != provider prediction, use_alt_on_na +1 when alt correct, else -1, saturating 0..15.
- If upd_pred==upd_taken or provider==NUM_TABLES: return to IDLE after PROV.
- Otherwise (mispredict), candidates = tables j>provider with upd_u_vec[j-1]=1.
- ALLOC (one or more candidates):
  - Write the first candidate: mask {1,1,1}, tag = upd_tag slice, u=0.
  - ctr = 2^(CTR_W-1) if taken, else 2^(CTR_W-1)-1.
  - TICK -1, saturating at 0.
- DECAY (no candidates):
  - One write per cycle, j = provider+1..NUM_TABLES, mask {0,0,1}.
  - wr_u = 0: clears u from 1 to 0, and u==0 stays 0 (u already read 0 isn't in the set by definition, so this amounts to write u-1 with the engine supplying the value). The engine has no u value for non-providers; table RAM applies decrement when mask==3'b001 and wr_u==0, saturating at 0.
  - TICK +1, saturating.
- If TICK reaches all-ones after ALLOC/DECAY: enter SWEEP.
  - wr_bcast=1, mask {0,0,1}, wr_u=0, wr_idx 0..2^IDX_W-1, one index per cycle.
  - TICK cleared on exit.
- LFSR advances once per accepted update.

Optional Feature:
- Macro: TAGE_ALLOC_RANDOM_EN.
- Defined: when two or more candidates exist and LFSR bit0=1, allocate the second candidate instead of the first.
- Undefined: always allocate the first candidate; LFSR logic removed.

Test Plan:
- Correct base prediction: provider=0, prov_ctr=2, taken=1, pred=1 -> one write T0, ctr=3, mask 3'b010; ready back in 2 cycles.
- Provider disagreeing with alt: provider=3, ctr=7, u=3, taken=1, pred=1, alt=0 -> T3 ctr=7, u=3 (saturated), mask 3'b011, no allocation.
- Mispredict with free slots: provider=2, pred=1, taken=0, u_vec bits for T5,T7 set -> PROV write, then T5 alloc with ctr=3, u=0, tag=slice 4; TICK unchanged at 0.
- Mispredict with no free slots: provider=10, NUM_TABLES=12, u_vec=0 -> decay writes to T11,T12 on consecutive cycles; TICK=1.
- TICK saturation: TICK_W=2, three failed allocations -> SWEEP of 2048 broadcast writes; upd_ready low throughout; TICK=0 after.
- Reset asserted mid-DECAY -> wr_valid=0 immediately; upd_ready=1 and use_alt_on_na=8 after release.
